// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed 32x32 multiplier / 32/32 divider that
// owns the architectural Hi and Lo registers.
//
// Optional build macro: MULT_DIV_UNSIGNED_EN adds op_unsigned (multu/divu).
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   a, b         operands (rs / rt), latched on the start edge
//   start_mult   one-cycle request: Hi:Lo = a*b
//   start_div    one-cycle request: Lo = a/b, Hi = a%b (mult wins if both)
//   op_unsigned  (MULT_DIV_UNSIGNED_EN only) 1 = unsigned operation
//   hi, lo       Hi / Lo registers, written only on the FIX edge
//   busy         high while an operation is in flight
//   done         one-cycle pulse after hi/lo are written
//   div_zero     one-cycle pulse with done when a divide had b == 0
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mag_a, mag_b, orig_a;
  logic               res_neg, rem_neg, is_div, b_zero;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic               uns;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns = op_unsigned;
`else
  assign uns = 1'b0;
`endif

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    abs_a    = (a[WIDTH-1] && !uns) ? -a : a;
    abs_b    = (b[WIDTH-1] && !uns) ? -b : b;
    // Multiply: add multiplicand into the upper half when the low bit of the
    // multiplier (held in acc's lower half) is set; carry is kept for the shift.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    // Divide: trial-subtract divisor from the remainder shifted left by one.
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    prod     = res_neg ? -acc : acc;
    quo      = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem      = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      orig_a   <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            orig_a  <= a;
            res_neg <= !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg <= !start_mult && !uns && a[WIDTH-1];
            is_div  <= !start_mult;
            b_zero  <= (b == '0);
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, (start_mult ? abs_b : abs_a)};
            state   <= start_mult ? MUL : DIV;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        DIV: begin
          if (!div_diff[WIDTH])
            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else
            acc <= {acc[2*WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div && b_zero) begin
            hi       <= orig_a;
            lo       <= '1;
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic        start_mult, start_div;
`ifdef MULT_DIV_UNSIGNED_EN
  logic        op_unsigned;
`endif
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a          (a),
    .b          (b),
    .start_mult (start_mult),
    .start_div  (start_div),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done. Operands are scrambled
  // right after the start edge to show they were latched.
  task automatic run_op(input bit m, input bit d, input logic [31:0] x,
                        input logic [31:0] y, output int lat, output int bcnt,
                        output bit dz);
    a = x; b = y; start_mult = m; start_div = d;
    tick();
    start_mult = 0; start_div = 0; a = ~x; b = ~y;
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (busy === 1'b1) bcnt++;
    end
    dz = div_zero;
  endtask

  task automatic test_reset();
    reset_n = 0; start_mult = 0; start_div = 0; a = '0; b = '0;
`ifdef MULT_DIV_UNSIGNED_EN
    op_unsigned = 0;
`endif
    repeat (3) tick();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", div_zero); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_mult();
    int lat, bcnt; bit dz;
    run_op(1, 0, 32'd7, 32'hFFFFFFFD, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_7x-3_hi got %h want %h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_7x-3_lo got %h want %h", lo, 32'hFFFFFFEB); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_width got %b want 0", done); end
    run_op(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, lat, bcnt, dz);
    checks++; if (hi !== 32'h3FFFFFFF) begin errors++; $display("FAIL mult_max_hi got %h want %h", hi, 32'h3FFFFFFF); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mult_max_lo got %h want %h", lo, 32'h1); end
    checks++; if (bcnt !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bcnt); end
    run_op(1, 0, 32'hFFFFFFFA, 32'hFFFFFFFB, lat, bcnt, dz);
    checks++; if ({hi, lo} !== 64'd30) begin errors++; $display("FAIL mult_neg_neg got %h want %h", {hi, lo}, 64'd30); end
    // Both starts high: mult must win (div would give lo=0, hi=6).
    run_op(1, 1, 32'd6, 32'd7, lat, bcnt, dz);
    checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL both_starts got %h want %h", {hi, lo}, 64'd42); end
    tick();
  endtask

  task automatic test_div();
    int lat, bcnt; bit dz;
    run_op(0, 1, 32'hFFFFFFF9, 32'd2, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_-7/2_lo got %h want %h", lo, 32'hFFFFFFFD); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_-7/2_hi got %h want %h", hi, 32'hFFFFFFFF); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_-7/2_divzero got %b want 0", dz); end
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, dz);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", lo, 32'h80000000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
    run_op(0, 1, 32'd100, 32'hFFFFFFF9, lat, bcnt, dz);
    checks++; if (lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL div_100/-7_lo got %h want %h", lo, 32'hFFFFFFF2); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_100/-7_hi got %h want %h", hi, 32'd2); end
    run_op(0, 1, 32'hFFFFFF9C, 32'd7, lat, bcnt, dz);
    checks++; if (lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL div_-100/7_lo got %h want %h", lo, 32'hFFFFFFF2); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL div_-100/7_hi got %h want %h", hi, 32'hFFFFFFFE); end
    tick();
  endtask

  task automatic test_div_zero();
    int lat, bcnt; bit dz;
    run_op(0, 1, 32'd5, 32'd0, lat, bcnt, dz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", lat); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi got %h want %h", hi, 32'd5); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_lo got %h want %h", lo, 32'hFFFFFFFF); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz); end
    tick();
    checks++; if ({done, div_zero} !== 2'b00) begin errors++; $display("FAIL dz_pulse_width got %b want 00", {done, div_zero}); end
    run_op(0, 1, 32'hFFFFFFF9, 32'd0, lat, bcnt, dz);
    checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL dz_neg_hi got %h want %h", hi, 32'hFFFFFFF9); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit dz, seen;
    run_op(1, 0, 32'd3, 32'd4, lat, bcnt, dz);
    checks++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL seq_3x4 got %h want %h", {hi, lo}, 64'd12); end
    a = 32'd9; b = 32'd9; start_mult = 1;
    tick();
    start_mult = 0; a = 32'd1; b = 32'd1;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start_div = (lat == 5);
      if (lat == 5) begin a = 32'd100; b = 32'd3; end
      if (lat == 20) begin
        checks++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL seq_hold_during_busy got %h want %h", {hi, lo}, 64'd12); end
      end
      tick();
      lat++;
    end
    start_div = 0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL seq_latency got %0d want 33", lat); end
    checks++; if ({hi, lo} !== 64'd81) begin errors++; $display("FAIL seq_9x9 got %h want %h", {hi, lo}, 64'd81); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_no_queue got %b want 0", busy); end
    // Abort mid-operation with reset.
    a = 32'd3; b = 32'd5; start_div = 1;
    tick();
    start_div = 0;
    repeat (10) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    reset_n = 0;
    #1;
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo got %h want %h", {hi, lo}, 64'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (2) tick();
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen); end
    checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_no_write got %h want %h", {hi, lo}, 64'd0); end
  endtask

`ifdef MULT_DIV_UNSIGNED_EN
  task automatic test_unsigned();
    int lat, bcnt; bit dz;
    op_unsigned = 1;
    run_op(0, 1, 32'hFFFFFFFF, 32'd2, lat, bcnt, dz);
    checks++; if (lo !== 32'h7FFFFFFF) begin errors++; $display("FAIL divu_lo got %h want %h", lo, 32'h7FFFFFFF); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want %h", hi, 32'd1); end
    run_op(1, 0, 32'hFFFFFFFF, 32'd2, lat, bcnt, dz);
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL multu_hi got %h want %h", hi, 32'd1); end
    checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want %h", lo, 32'hFFFFFFFE); end
    op_unsigned = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
`ifdef MULT_DIV_UNSIGNED_EN
    test_unsigned();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
